// File: rtl/pattern_scan_pkg.sv
// Shared types and default address map for the pattern scan controller.
// Holds the FSM state enum and the default parameter values.
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_PAT,
        RD_BYTE,
        DRAIN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        FIN
    } state_e;

    localparam int unsigned NBYTES_DEF   = 32;
    localparam int unsigned PAT_ADDR_DEF = 32;
    localparam int unsigned RES_BASE_DEF = 33;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Start/done handshake plus data-memory bus of the pattern scanner.
// master: controller side; slave: memory/host side.
interface pattern_scan_ctrl_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    modport master (
        input  start, mem_rdata,
        output done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        output start, mem_rdata,
        input  done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/pattern_window_cnt.sv
// Counts 5-bit pattern hits inside cur and across the prev/cur boundary.
// Ports: pat, prev, cur, first -> inbyte_cnt, cross_cnt, any_hit.
module pattern_window_cnt (
    input  logic [4:0] pat,
    input  logic [7:0] prev,
    input  logic [7:0] cur,
    input  logic       first,
    output logic [2:0] inbyte_cnt,
    output logic [2:0] cross_cnt,
    output logic       any_hit
);
    logic [11:0] w;

    // w[7:0] is cur; windows at offsets 0..3 are in-byte,
    // offsets 4..7 straddle into the low nibble of prev.
    always_comb begin
        w          = {prev[3:0], cur};
        inbyte_cnt = 3'd0;
        cross_cnt  = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (w[k +: 5] == pat) inbyte_cnt = inbyte_cnt + 3'd1;
        end
        for (int k = 4; k < 8; k++) begin
            if (!first && w[k +: 5] == pat) cross_cnt = cross_cnt + 3'd1;
        end
        any_hit = (inbyte_cnt != 3'd0);
    end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans NBYTES memory bytes for a 5-bit pattern and writes three counts.
// Ports: clk, reset (async active-low), bus (start/done + memory bus).
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned NBYTES   = NBYTES_DEF,
    parameter int unsigned PAT_ADDR = PAT_ADDR_DEF,
    parameter int unsigned RES_BASE = RES_BASE_DEF
) (
    input logic                 clk,
    input logic                 reset,
    pattern_scan_ctrl_if.master bus
);
    state_e     state_q;
    logic [7:0] i_q;
    logic [4:0] pat_q;
    logic [7:0] prev_q, prev_d;
    logic [7:0] ctb_q, ctb_d;
    logic [7:0] cto_q, cto_d;
    logic [7:0] cts_q, cts_d;
    logic       done_q, rd_q, wr_q;
    logic [7:0] addr_q, wdata_q;

    logic       proc, first;
    logic [2:0] inb_cnt, crs_cnt;
    logic       hit;

    // Read data lags the address by one cycle, so RD_BYTE index i
    // sees byte i-1 and DRAIN sees the last byte.
    assign proc  = (state_q == DRAIN) ||
                   (state_q == RD_BYTE && i_q != 8'd0);
    assign first = (state_q == DRAIN) ? (NBYTES == 1) :
                   (i_q == 8'd1);

    pattern_window_cnt u_win (
        .pat        (pat_q),
        .prev       (prev_q),
        .cur        (bus.mem_rdata),
        .first      (first),
        .inbyte_cnt (inb_cnt),
        .cross_cnt  (crs_cnt),
        .any_hit    (hit)
    );

    always_comb begin
        ctb_d  = ctb_q;
        cto_d  = cto_q;
        cts_d  = cts_q;
        prev_d = prev_q;
        if (proc) begin
            ctb_d  = ctb_q + {5'd0, inb_cnt};
            cto_d  = cto_q + {7'd0, hit};
            cts_d  = cts_q + {5'd0, inb_cnt} + {5'd0, crs_cnt};
            prev_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            pat_q   <= 5'd0;
            prev_q  <= 8'd0;
            ctb_q   <= 8'd0;
            cto_q   <= 8'd0;
            cts_q   <= 8'd0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state_q <= RD_PAT;
                        done_q  <= 1'b0;
                        i_q     <= 8'd0;
                        pat_q   <= 5'd0;
                        prev_q  <= 8'd0;
                        ctb_q   <= 8'd0;
                        cto_q   <= 8'd0;
                        cts_q   <= 8'd0;
                        rd_q    <= 1'b1;
                        addr_q  <= 8'(PAT_ADDR);
                    end
                end
                RD_PAT: begin
                    state_q <= RD_BYTE;
                    i_q     <= 8'd0;
                    addr_q  <= 8'd0;
                    rd_q    <= 1'b1;
                end
                RD_BYTE: begin
                    if (i_q == 8'd0) pat_q <= bus.mem_rdata[7:3];
                    ctb_q  <= ctb_d;
                    cto_q  <= cto_d;
                    cts_q  <= cts_d;
                    prev_q <= prev_d;
                    if (i_q == 8'(NBYTES - 1)) begin
                        state_q <= DRAIN;
                        rd_q    <= 1'b0;
                        addr_q  <= 8'd0;
                    end else begin
                        i_q    <= i_q + 8'd1;
                        addr_q <= i_q + 8'd1;
                    end
                end
                DRAIN: begin
                    ctb_q   <= ctb_d;
                    cto_q   <= cto_d;
                    cts_q   <= cts_d;
                    prev_q  <= prev_d;
                    state_q <= WR_CTB;
                    wr_q    <= 1'b1;
                    addr_q  <= 8'(RES_BASE);
                    // last byte's contribution is not in ctb_q yet
                    wdata_q <= ctb_d;
                end
                WR_CTB: begin
                    state_q <= WR_CTO;
                    addr_q  <= 8'(RES_BASE + 1);
                    wdata_q <= cto_q;
                end
                WR_CTO: begin
                    state_q <= WR_CTS;
                    addr_q  <= 8'(RES_BASE + 2);
                    wdata_q <= cts_q;
                end
                WR_CTS: begin
                    state_q <= FIN;
                    wr_q    <= 1'b0;
                    addr_q  <= 8'd0;
                    wdata_q <= 8'd0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd_en = rd_q;
    assign bus.mem_wr_en = wr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl with a synchronous-read memory.
// Reference counts come from a bit-stream model of the scanned bytes.
module tb_pattern_scan_ctrl;
    localparam int NB = 32;
    localparam int PA = 32;
    localparam int RB = 33;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   overlap  = 0;
    logic [7:0] mem [256];

    pattern_scan_ctrl_if bus ();

    pattern_scan_ctrl #(
        .NBYTES   (NB),
        .PAT_ADDR (PA),
        .RES_BASE (RB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rd_en && bus.mem_wr_en) overlap = overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bit_at(input int s);
        logic [7:0] b;
        b = mem[s / 8];
        return int'(b[7 - (s % 8)]);
    endfunction

    // Stream view: byte 0 is most significant; cts is simply the number
    // of pattern hits at every bit offset of the whole stream.
    function automatic void model(output int ctb, output int cto,
                                  output int cts);
        int p, h, v;
        p   = int'(mem[PA][7:3]);
        ctb = 0;
        cto = 0;
        cts = 0;
        for (int b = 0; b < NB; b++) begin
            h = 0;
            for (int k = 0; k < 4; k++)
                if (((int'(mem[b]) >> (3 - k)) & 31) == p) h++;
            ctb += h;
            if (h > 0) cto++;
        end
        for (int s = 0; s <= 8 * NB - 5; s++) begin
            v = 0;
            for (int k = 0; k < 5; k++) v = v * 2 + bit_at(s + k);
            if (v == p) cts++;
        end
        ctb = ctb % 256;
        cto = cto % 256;
        cts = cts % 256;
    endfunction

    task automatic run_check(input string tag, input bit poke);
        int ctb, cto, cts, cyc, w0;
        model(ctb, cto, cts);
        mem[RB]     = 8'hEE;
        mem[RB + 1] = 8'hEE;
        mem[RB + 2] = 8'hEE;
        w0 = wr_count;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_done_drop"}, 32'(bus.done), 0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 10) bus.start = 1'b1;
            if (poke && cyc == 12) bus.start = 1'b0;
        end
        chk({tag, "_cycles"}, cyc, NB + 5);
        chk({tag, "_ctb"}, 32'(mem[RB]), ctb);
        chk({tag, "_cto"}, 32'(mem[RB + 1]), cto);
        chk({tag, "_cts"}, 32'(mem[RB + 2]), cts);
        chk({tag, "_writes"}, wr_count - w0, 3);
    endtask

    task automatic chk3(input string tag, input int a, input int b,
                        input int c);
        chk({tag, "_ctb_abs"}, 32'(mem[RB]), a);
        chk({tag, "_cto_abs"}, 32'(mem[RB + 1]), b);
        chk({tag, "_cts_abs"}, 32'(mem[RB + 2]), c);
    endtask

    task automatic fill(input logic [7:0] patb, input logic [7:0] v);
        for (int b = 0; b < NB; b++) mem[b] = v;
        mem[PA] = patb;
    endtask

    initial begin
        int w0;
        logic [4:0] p;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rd", 32'(bus.mem_rd_en), 0);
        chk("rst_wr", 32'(bus.mem_wr_en), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_rd", 32'(bus.mem_rd_en), 0);

        fill(8'b00000_101, 8'h00);
        run_check("zeros", 1'b0);
        chk3("zeros", 128, 32, 252);

        fill(8'b01010_000, 8'h55);
        run_check("alt55", 1'b0);
        chk3("alt55", 64, 32, 126);

        fill(8'b11111_000, 8'h00);
        mem[0] = 8'h07;
        mem[1] = 8'hC0;
        run_check("cross", 1'b0);
        chk3("cross", 0, 0, 1);

        fill(8'b11111_011, 8'h00);
        run_check("nohit", 1'b0);
        chk3("nohit", 0, 0, 0);

        fill(8'b00000_000, 8'h00);
        run_check("poke", 1'b1);
        chk3("poke", 128, 32, 252);
        chk("fin_done", 32'(bus.done), 1);
        run_check("fin_rerun", 1'b0);

        // abort a run with a mid-cycle reset pulse
        fill(8'b01010_000, 8'h55);
        mem[RB] = 8'hEE;
        mem[RB + 1] = 8'hEE;
        mem[RB + 2] = 8'hEE;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_rd", 32'(bus.mem_rd_en), 0);
        chk("abort_addr", 32'(bus.mem_addr), 0);
        chk("abort_done", 32'(bus.done), 0);
        #1 reset = 1'b1;
        w0 = wr_count;
        repeat (50) @(posedge clk);
        #1;
        chk("abort_writes", wr_count - w0, 0);
        chk("abort_done_hold", 32'(bus.done), 0);
        chk("abort_mem", 32'(mem[RB]), 32'hEE);
        run_check("after_abort", 1'b0);
        chk3("after_abort", 64, 32, 126);

        for (int r = 0; r < 6; r++) begin
            p = 5'($urandom);
            for (int b = 0; b < NB; b++)
                mem[b] = ($urandom_range(0, 1) == 1) ? 8'($urandom) :
                         8'({p, 3'($urandom)} >> $urandom_range(0, 3));
            mem[PA] = {p, 3'($urandom)};
            run_check($sformatf("rand%0d", r), r[0]);
        end

        chk("rd_wr_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter NBYTES, default 32: number of message bytes scanned, held at addresses 0..NBYTES-1.
REQ-002 Parameter PAT_ADDR, default 32: data-memory address of the pattern byte, with the pattern in bits [7:3].
REQ-003 Parameter RES_BASE, default 33: first result address; ctb at RES_BASE, cto at RES_BASE+1, cts at RES_BASE+2.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled high on a clk edge.
REQ-007 done  output  1  level; high when results are written, held until the next accepted start.
REQ-008 mem_addr  output  8  data-memory address.
REQ-009 mem_rd_en  output  1  read strobe; mem_rdata is valid exactly one cycle after mem_rd_en is high.
REQ-010 mem_rdata  input  8  read data.
REQ-011 mem_wr_en  output  1  write strobe; mem_wdata is written to mem_addr at the same edge.
REQ-012 mem_wdata  output  8  write data.

Function
REQ-013 The FSM SHALL have states IDLE, RD_PAT, RD_BYTE, DRAIN, WR_CTB, WR_CTO, WR_CTS and FIN.
REQ-014 IDLE or FIN with start=1 -> RD_PAT; done drops at that edge and all counters clear.
REQ-015 While the FSM is in any other state, start SHALL be ignored.
REQ-016 RD_PAT: addr=PAT_ADDR, rd_en=1, for one cycle, then -> RD_BYTE with index i=0.
REQ-017 RD_BYTE: addr=i, rd_en=1, for NBYTES back-to-back cycles (i=0..NBYTES-1), then -> DRAIN.
REQ-018 In the first RD_BYTE cycle, mem_rdata[7:3] SHALL be latched as pat.
REQ-019 In each later RD_BYTE cycle and in DRAIN, mem_rdata is byte i-1 and SHALL be processed.
REQ-020 For each processed byte b: ctb += number of matches of pat against b[7:3], b[6:2], b[5:1] and b[4:0] (0..4).
REQ-021 For each processed byte b: cto += 1 if any of those four windows matches.
REQ-022 For each processed byte b that is not byte 0, with p = the previous byte: cts += matches against {p[3:0],b[7]}, {p[2:0],b[7:6]}, {p[1:0],b[7:5]} and {p[0],b[7:4]}, plus the in-byte match count.
REQ-023 For byte 0, cts SHALL add only the in-byte match count.
REQ-024 Byte 0 SHALL be treated as the most significant byte of the stream.
REQ-025 Counters SHALL be 8 bits and non-saturating; maxima are 128, 32 and 252 for NBYTES=32.
REQ-026 WR_CTB, WR_CTO and WR_CTS SHALL each last one cycle with wr_en=1, writing their count to RES_BASE+0, +1 and +2 respectively, then -> FIN.
REQ-027 done SHALL be high in FIN, 37 cycles after the edge that accepted start (NBYTES=32).
REQ-028 mem_rd_en and mem_wr_en SHALL never be high together.
REQ-029 In IDLE and FIN, mem_rd_en=0 and mem_wr_en=0.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, with done=0, rd_en=0, wr_en=0, mem_addr=0, mem_wdata=0, all counters, pat and the previous-byte register at 0, and i=0.
REQ-031 A reset during a run SHALL abort it; no result write follows, and a fresh start is required.

Structure
REQ-032 The shared package pattern_scan_pkg SHALL hold the state enum and default address constants 32/33.
REQ-033 Window matching SHALL be a combinational sub-module pattern_window_cnt, with inputs pat, prev and cur, a first-byte flag, and outputs inbyte_cnt[2:0], cross_cnt[2:0] and any_hit.

Verification
REQ-034 pat=00000, all bytes 0x00 -> mem[33]=128, mem[34]=32, mem[35]=252, with done at cycle 37.
REQ-035 pat=01010, all bytes 0x55 -> mem[33]=64, mem[34]=32, mem[35]=126.
REQ-036 pat=11111, byte0=0x07, byte1=0xC0, rest 0x00 -> 0, 0, 1 (crossing-only hit).
REQ-037 pat=11111, all bytes 0x00 -> 0, 0, 0, with exactly three write strobes.
REQ-038 reset pulsed low at cycle 20 of a run -> no writes, done stays 0, and a new start completes correctly.
REQ-039 start re-asserted during RD_BYTE -> ignored, with results and timing unchanged; start in FIN -> a clean rerun.
